// File: rtl/serial_sub_pkg.sv
// Shared types and helpers for the bit-serial subtractor.
// Holds the FSM state encoding and the iteration counter sizing.
package serial_sub_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Width of a counter that indexes 0..width-1 (never narrower than 1 bit).
    function automatic int count_width(input int width);
        return (width > 2) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/fs_bit_cell.sv
// Single-bit full subtractor: d = a - b - bin, with the borrow out of this bit.
module fs_bit_cell (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor: one full-subtractor cell iterated LSB first,
// with a start/busy/done handshake and registered diff/borrow_out.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);

    localparam int             CW   = count_width(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic [WIDTH-1:0] res_sr_q, res_sr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             borrow_q, borrow_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_out_q, borrow_out_d;
    logic             done_q, done_d;

    logic             cell_d;
    logic             cell_bout;
    logic [WIDTH-1:0] res_shifted;

    fs_bit_cell u_cell (
        .a    (a_sr_q[0]),
        .b    (b_sr_q[0]),
        .bin  (borrow_q),
        .d    (cell_d),
        .bout (cell_bout)
    );

    // This edge's result bit enters at the MSB so the LSB lands at bit 0 after WIDTH shifts.
    assign res_shifted = {cell_d, res_sr_q[WIDTH-1:1]};

    always_comb begin
        // NOTE: every signal gets a hold/default value first so no path leaves it unassigned (no latch).
        state_d      = state_q;
        a_sr_d       = a_sr_q;
        b_sr_d       = b_sr_q;
        res_sr_d     = res_sr_q;
        count_d      = count_q;
        borrow_d     = borrow_q;
        diff_d       = diff_q;
        borrow_out_d = borrow_out_q;
        done_d       = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = RUN;
                    a_sr_d   = a_in;
                    b_sr_d   = b_in;
                    res_sr_d = '0;
                    borrow_d = 1'b0;
                    count_d  = '0;
                end
            end
            RUN: begin
                a_sr_d   = a_sr_q >> 1;
                b_sr_d   = b_sr_q >> 1;
                res_sr_d = res_shifted;
                borrow_d = cell_bout;
                count_d  = count_q + CW'(1);
                if (count_q == LAST) begin
                    state_d      = IDLE;
                    diff_d       = res_shifted;
                    borrow_out_d = cell_bout;
                    done_d       = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            a_sr_q       <= '0;
            b_sr_q       <= '0;
            res_sr_q     <= '0;
            count_q      <= '0;
            borrow_q     <= 1'b0;
            diff_q       <= '0;
            borrow_out_q <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            a_sr_q       <= a_sr_d;
            b_sr_q       <= b_sr_d;
            res_sr_q     <= res_sr_d;
            count_q      <= count_d;
            borrow_q     <= borrow_d;
            diff_q       <= diff_d;
            borrow_out_q <= borrow_out_d;
            done_q       <= done_d;
        end
    end

    assign busy       = (state_q == RUN);
    assign done       = done_q;
    assign diff       = diff_q;
    assign borrow_out = borrow_out_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and exhaustive checks of serial_subtractor at WIDTH=8 and WIDTH=4.
module tb_serial_subtractor;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       start8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       busy8, done8, borrow8;
    logic [7:0] diff8;

    logic       start4 = 1'b0;
    logic [3:0] a4 = '0, b4 = '0;
    logic       busy4, done4, borrow4;
    logic [3:0] diff4;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(8)) u_dut8 (
        .clk        (clk),
        .rst        (rst),
        .start      (start8),
        .a_in       (a8),
        .b_in       (b8),
        .busy       (busy8),
        .done       (done8),
        .diff       (diff8),
        .borrow_out (borrow8)
    );

    serial_subtractor #(.WIDTH(4)) u_dut4 (
        .clk        (clk),
        .rst        (rst),
        .start      (start4),
        .a_in       (a4),
        .b_in       (b4),
        .busy       (busy4),
        .done       (done4),
        .diff       (diff4),
        .borrow_out (borrow4)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called at a negedge: requests a - b, then waits (bounded) for done.
    // Returns at the negedge where done is high; cycles counts negedges waited.
    task automatic run8(input logic [7:0] a, input logic [7:0] b, output int cycles);
        start8 = 1'b1;
        a8     = a;
        b8     = b;
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
            start8 = 1'b0;
        end while (!done8 && cycles < 30);
    endtask

    task automatic count_done8(input int n, output int dones);
        dones = 0;
        repeat (n) begin
            @(negedge clk);
            if (done8) dones++;
        end
    endtask

    initial begin
        int cyc;
        int dones;
        int total4;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("rst_busy", busy8, 0);
        check("rst_done", done8, 0);
        check("rst_diff", diff8, 0);
        check("rst_borrow", borrow8, 0);
        rst = 1'b0;

        // Basic op with latency and busy/hold observation
        start8 = 1'b1; a8 = 8'h5A; b8 = 8'h3C;
        @(negedge clk);
        start8 = 1'b0;
        a8 = 8'hFF; b8 = 8'hFF;
        check("run_busy", busy8, 1);
        check("run_diff_hold", diff8, 0);
        cyc = 1;
        while (!done8 && cyc < 30) begin
            @(negedge clk);
            cyc++;
        end
        check("lat_5a_3c", cyc, 9);
        check("diff_5a_3c", diff8, 8'h1E);
        check("bor_5a_3c", borrow8, 0);
        check("done_busy", busy8, 0);
        @(negedge clk);
        check("done_pulse", done8, 0);
        check("diff_held", diff8, 8'h1E);

        run8(8'h03, 8'h05, cyc);
        check("lat_03_05", cyc, 9);
        check("diff_03_05", diff8, 8'hFE);
        check("bor_03_05", borrow8, 1);
        @(negedge clk);

        run8(8'h00, 8'hFF, cyc);
        check("lat_00_ff", cyc, 9);
        check("diff_00_ff", diff8, 8'h01);
        check("bor_00_ff", borrow8, 1);
        @(negedge clk);

        // a=b=0, then back-to-back start issued in its done cycle
        run8(8'h00, 8'h00, cyc);
        check("lat_00_00", cyc, 9);
        check("diff_00_00", diff8, 8'h00);
        check("bor_00_00", borrow8, 0);
        run8(8'h80, 8'h7F, cyc);
        check("lat_b2b", cyc, 9);
        check("diff_80_7f", diff8, 8'h01);
        check("bor_80_7f", borrow8, 0);
        @(negedge clk);
        check("b2b_done_pulse", done8, 0);

        // Start pulsed during RUN is ignored
        start8 = 1'b1; a8 = 8'h10; b8 = 8'h01;
        @(negedge clk);
        start8 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("ign_diff_hold", diff8, 8'h01);
        start8 = 1'b1; a8 = 8'hFF; b8 = 8'h00;
        @(negedge clk);
        start8 = 1'b0;
        cyc = 4;
        while (!done8 && cyc < 30) begin
            @(negedge clk);
            cyc++;
        end
        check("lat_ign", cyc, 9);
        check("diff_10_01", diff8, 8'h0F);
        check("bor_10_01", borrow8, 0);
        count_done8(12, dones);
        check("ign_no_second_done", dones, 0);
        check("ign_idle", busy8, 0);

        // Reset in the middle of RUN aborts the operation
        start8 = 1'b1; a8 = 8'h5A; b8 = 8'h3C;
        @(negedge clk);
        start8 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_busy", busy8, 0);
        check("abort_done", done8, 0);
        check("abort_diff", diff8, 0);
        check("abort_borrow", borrow8, 0);
        rst = 1'b0;
        count_done8(12, dones);
        check("abort_no_done", dones, 0);

        run8(8'h5A, 8'h3C, cyc);
        check("lat_fresh", cyc, 9);
        check("diff_fresh", diff8, 8'h1E);
        check("bor_fresh", borrow8, 0);
        @(negedge clk);

        // Exhaustive WIDTH=4 sweep against an arithmetic model
        total4 = 0;
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                logic [3:0] ea;
                logic [3:0] eb;
                logic [3:0] exp_d;
                int         d4;
                ea     = 4'(a);
                eb     = 4'(b);
                exp_d  = ea - eb;
                start4 = 1'b1;
                a4     = ea;
                b4     = eb;
                d4     = 0;
                repeat (7) begin
                    @(negedge clk);
                    start4 = 1'b0;
                    if (done4) d4++;
                end
                total4 += d4;
                check($sformatf("w4_done_%0d_%0d", a, b), d4, 1);
                check($sformatf("w4_diff_%0d_%0d", a, b), diff4, exp_d);
                check($sformatf("w4_bor_%0d_%0d", a, b), borrow4, (a < b) ? 1 : 0);
            end
        end
        check("w4_total_done", total4, 256);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
